// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, queue sizing and source encoding for the CDB arbiter
package cdb_arbiter_pkg;
    localparam int ROB_SIZE_WIDTH = 4;
    localparam int CDB_QUEUE_DEPTH = 4;
    localparam int CDB_QUEUE_DEPTH_WIDTH = 2;
    localparam int CDB_DATA_WIDTH = 32;
    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_MEM = 1'b1
    } cdb_src_e;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer handshakes (ALU, MEM) and the common data bus broadcast
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
    parameter int RW = ROB_SIZE_WIDTH
) ();
    logic                      alu_valid;
    logic [CDB_DATA_WIDTH-1:0] alu_value;
    logic [RW-1:0]             alu_rob_id;
    logic                      alu_ready;
    logic                      mem_valid;
    logic [CDB_DATA_WIDTH-1:0] mem_value;
    logic [RW-1:0]             mem_rob_id;
    logic                      mem_ready;
    logic                      cdb_valid;
    logic [CDB_DATA_WIDTH-1:0] cdb_value;
    logic [RW-1:0]             cdb_rob_id;
    logic                      cdb_src;

    modport master (
        output alu_valid, alu_value, alu_rob_id, mem_valid, mem_value, mem_rob_id,
        input  alu_ready, mem_ready, cdb_valid, cdb_value, cdb_rob_id, cdb_src
    );
    modport slave (
        input  alu_valid, alu_value, alu_rob_id, mem_valid, mem_value, mem_rob_id,
        output alu_ready, mem_ready, cdb_valid, cdb_value, cdb_rob_id, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: small synchronous FIFO with async reset and synchronous clear; caller never pushes full or pops empty
module cdb_fifo #(
    parameter int WIDTH       = 36,
    parameter int DEPTH       = 4,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [DEPTH_WIDTH:0]   count
);
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;

    assign dout = mem[rd_ptr];

    // storage needs no reset: count alone decides which slots are live
    always_ff @(posedge clk_in)
        if (push && !clr) mem[wr_ptr] <= din;

    // pointers wrap naturally modulo the power-of-two depth
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + DEPTH_WIDTH'(push);
            rd_ptr <= rd_ptr + DEPTH_WIDTH'(pop);
            count  <= count + (DEPTH_WIDTH+1)'(push) - (DEPTH_WIDTH+1)'(pop);
        end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin merge of ALU and MEM writebacks onto one CDB; CDB_BYPASS_EN forwards into an idle bus
module cdb_arbiter import cdb_arbiter_pkg::*; #(
    parameter int ROB_SIZE_WIDTH    = cdb_arbiter_pkg::ROB_SIZE_WIDTH,
    parameter int QUEUE_DEPTH       = CDB_QUEUE_DEPTH,
    parameter int QUEUE_DEPTH_WIDTH = CDB_QUEUE_DEPTH_WIDTH
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    cdb_arbiter_if.slave  bus
);
    localparam int DW = CDB_DATA_WIDTH + ROB_SIZE_WIDTH;
    localparam logic [QUEUE_DEPTH_WIDTH:0] FULL = (QUEUE_DEPTH_WIDTH+1)'(QUEUE_DEPTH);

    logic                     en, clr;
    logic [QUEUE_DEPTH_WIDTH:0] alu_cnt, mem_cnt;
    logic [DW-1:0]            alu_head, mem_head, alu_sel, mem_sel, grant_data;
    logic                     alu_ne, mem_ne, alu_acc, mem_acc, alu_cand, mem_cand;
    logic                     alu_push, mem_push, alu_pop, mem_pop, grant_any;
    cdb_src_e                 rr_ptr, grant_src;

    assign en  = rdy_in && !flush_in;
    assign clr = rdy_in && flush_in;
    assign bus.alu_ready = en && alu_cnt != FULL;
    assign bus.mem_ready = en && mem_cnt != FULL;
    assign alu_acc = bus.alu_valid && bus.alu_ready;
    assign mem_acc = bus.mem_valid && bus.mem_ready;
    assign alu_ne  = alu_cnt != '0;
    assign mem_ne  = mem_cnt != '0;

    // candidate selection, grant and FIFO push/pop decisions for this edge
    always_comb begin
`ifdef CDB_BYPASS_EN
        alu_cand = alu_ne || alu_acc;
        mem_cand = mem_ne || mem_acc;
        alu_sel  = alu_ne ? alu_head : {bus.alu_value, bus.alu_rob_id};
        mem_sel  = mem_ne ? mem_head : {bus.mem_value, bus.mem_rob_id};
`else
        alu_cand = alu_ne;
        mem_cand = mem_ne;
        alu_sel  = alu_head;
        mem_sel  = mem_head;
`endif
        grant_any  = alu_cand || mem_cand;
        grant_src  = (mem_cand && (!alu_cand || rr_ptr == CDB_SRC_MEM)) ? CDB_SRC_MEM : CDB_SRC_ALU;
        grant_data = grant_src == CDB_SRC_MEM ? mem_sel : alu_sel;
        alu_pop    = en && alu_ne && grant_src == CDB_SRC_ALU;
        mem_pop    = en && mem_ne && grant_src == CDB_SRC_MEM;
`ifdef CDB_BYPASS_EN
        alu_push   = alu_acc && !(grant_src == CDB_SRC_ALU && !alu_ne);
        mem_push   = mem_acc && !(grant_src == CDB_SRC_MEM && !mem_ne);
`else
        alu_push   = alu_acc;
        mem_push   = mem_acc;
`endif
    end

    cdb_fifo #(.WIDTH(DW), .DEPTH(QUEUE_DEPTH), .DEPTH_WIDTH(QUEUE_DEPTH_WIDTH)) u_alu_fifo (
        .clk_in(clk_in), .rst_in(rst_in), .clr(clr), .push(alu_push), .pop(alu_pop),
        .din({bus.alu_value, bus.alu_rob_id}), .dout(alu_head), .count(alu_cnt)
    );

    cdb_fifo #(.WIDTH(DW), .DEPTH(QUEUE_DEPTH), .DEPTH_WIDTH(QUEUE_DEPTH_WIDTH)) u_mem_fifo (
        .clk_in(clk_in), .rst_in(rst_in), .clr(clr), .push(mem_push), .pop(mem_pop),
        .din({bus.mem_value, bus.mem_rob_id}), .dout(mem_head), .count(mem_cnt)
    );

    // broadcast registers and round-robin pointer; everything holds while rdy_in is low
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            rr_ptr         <= CDB_SRC_ALU;
            bus.cdb_valid  <= 1'b0;
            bus.cdb_value  <= '0;
            bus.cdb_rob_id <= '0;
            bus.cdb_src    <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                rr_ptr        <= CDB_SRC_ALU;
                bus.cdb_valid <= 1'b0;
            end else if (grant_any) begin
                bus.cdb_valid                   <= 1'b1;
                {bus.cdb_value, bus.cdb_rob_id} <= grant_data;
                bus.cdb_src                     <= grant_src;
                rr_ptr <= grant_src == CDB_SRC_ALU ? CDB_SRC_MEM : CDB_SRC_ALU;
            end else begin
                bus.cdb_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed-plus-random bench comparing the CDB arbiter against a queue-based reference model
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
    always #5 clk_in = ~clk_in;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .bus(bus)
    );

    int vectors = 0, miscompares = 0;
    logic [35:0] aq[$], mq[$];
    bit          rr;
    logic        exp_v, exp_src;
    logic [31:0] exp_val;
    logic [3:0]  exp_rob;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        mq.delete();
        rr = 0;
        exp_v = 0;
        exp_src = 0;
        exp_val = '0;
        exp_rob = '0;
    endtask

    // one clock edge of the reference: queues, round-robin choice, broadcast registers
    task automatic model_edge();
        bit aa, ma, ac, mc, gm;
        logic [35:0] e;
        if (!rdy_in) return;
        if (flush_in) begin
            aq.delete();
            mq.delete();
            exp_v = 0;
            rr = 0;
            return;
        end
        aa = bus.alu_valid && aq.size() < 4;
        ma = bus.mem_valid && mq.size() < 4;
`ifdef CDB_BYPASS_EN
        ac = aq.size() > 0 || aa;
        mc = mq.size() > 0 || ma;
`else
        ac = aq.size() > 0;
        mc = mq.size() > 0;
`endif
        if (ac || mc) begin
            gm = mc && (!ac || rr);
            if (gm) begin
                if (mq.size() > 0) e = mq.pop_front();
                else begin e = {bus.mem_value, bus.mem_rob_id}; ma = 0; end
            end else begin
                if (aq.size() > 0) e = aq.pop_front();
                else begin e = {bus.alu_value, bus.alu_rob_id}; aa = 0; end
            end
            exp_v = 1;
            exp_val = e[35:4];
            exp_rob = e[3:0];
            exp_src = gm;
            rr = !gm;
        end else begin
            exp_v = 0;
        end
        if (aa) aq.push_back({bus.alu_value, bus.alu_rob_id});
        if (ma) mq.push_back({bus.mem_value, bus.mem_rob_id});
    endtask

    task automatic chk_cdb(input string pfx);
        chk({pfx, "cdb_valid"}, bus.cdb_valid, exp_v);
        chk({pfx, "cdb_value"}, bus.cdb_value, exp_val);
        chk({pfx, "cdb_rob_id"}, bus.cdb_rob_id, exp_rob);
        chk({pfx, "cdb_src"}, bus.cdb_src, exp_src);
    endtask

    task automatic tick();
        @(negedge clk_in);
        chk("alu_ready", bus.alu_ready, rdy_in && !flush_in && aq.size() < 4);
        chk("mem_ready", bus.mem_ready, rdy_in && !flush_in && mq.size() < 4);
        @(posedge clk_in);
        model_edge();
        #1;
        chk_cdb("");
    endtask

    task automatic drive(input logic av, input logic [31:0] aval, input logic [3:0] arob,
                         input logic mv, input logic [31:0] mval, input logic [3:0] mrob);
        bus.alu_valid = av;
        bus.alu_value = aval;
        bus.alu_rob_id = arob;
        bus.mem_valid = mv;
        bus.mem_value = mval;
        bus.mem_rob_id = mrob;
    endtask

    task automatic idle(input int n);
        drive(0, '0, '0, 0, '0, '0);
        repeat (n) tick();
    endtask

    task automatic dual(input int n);
        repeat (n) begin
            drive(1, $urandom, 4'($urandom), 1, $urandom, 4'($urandom));
            tick();
        end
    endtask

    // asynchronous reset pulse between edges; outputs must clear with no clock
    task automatic do_reset();
        #1 rst_in = 1;
        #1 model_reset();
        chk_cdb("rst_");
        rst_in = 0;
    endtask

    initial begin
        int t;
        drive(0, '0, '0, 0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk_cdb("reset_");
        rst_in = 0;

        // single ALU result
        drive(1, 32'h1234, 4'd3, 0, '0, '0);
        tick();
        idle(4);

        // simultaneous results right after reset, then continuous dual traffic
        do_reset();
        drive(1, 32'hA, 4'd1, 1, 32'hB, 4'd2);
        tick();
        dual(8);
        idle(8);

        // ALU fills its FIFO while MEM keeps the bus busy
        t = 4;
        for (int i = 0; i < 40 && t <= 9; i++) begin
            bit acc;
            drive(1, 32'h100 + 32'(t), 4'(t), 1, $urandom, 4'($urandom));
            acc = aq.size() < 4;
            tick();
            if (acc) t++;
        end
        idle(12);

        // flush with entries queued; nothing queued may appear afterwards
        dual(3);
        drive(1, $urandom, 4'($urandom), 1, $urandom, 4'($urandom));
        flush_in = 1;
        tick();
        flush_in = 0;
        idle(2);
        drive(1, 32'hC, 4'd5, 1, 32'hD, 4'd6);
        tick();
        idle(4);

        // stall with a valid broadcast on the bus
        dual(4);
        rdy_in = 0;
        dual(3);
        rdy_in = 1;
        idle(10);

        // randomized traffic with occasional stalls and flushes
        for (int i = 0; i < 400; i++) begin
            rdy_in = ($urandom % 8) != 0;
            flush_in = ($urandom % 25) == 0;
            drive(($urandom % 4) != 0, $urandom, 4'($urandom),
                  ($urandom % 3) != 0, $urandom, 4'($urandom));
            tick();
        end
        rdy_in = 1;
        flush_in = 0;
        idle(10);

        // asynchronous reset in the middle of a burst
        dual(3);
        do_reset();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
